// File: rtl/flo_scan.sv
// flo_scan: captures a WID-bit vector and emits the index of every set bit,
// one index per accepted beat, lowest-first (dir=0) or highest-first (dir=1).
// Optional feature macro: FLO_SCAN_POPCNT_EN (cnt reports the popcount of the
// loaded vector; when undefined cnt is tied to zero).
module flo_scan #(
  parameter int WID = 64,
  parameter int OW  = $clog2(WID) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic [WID-1:0] i,
  input  logic           dir,
  output logic           busy,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [OW-1:0]  o,
  output logic           last,
  output logic           empty,
  output logic [OW-1:0]  cnt
);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e         state_q, state_d;
  logic [WID-1:0] v_q, v_d;
  logic           d_q, d_d;
  logic           empty_q, empty_d;

  logic [OW-1:0]  enc;
  logic [WID-1:0] sel;
  logic           le_one;
  logic           acc;

  // Priority search on v: the index reported this beat and its one-hot mask.
  // For d=0 the loop runs downward so the lowest set bit is the last writer;
  // for d=1 it runs upward so the highest set bit wins.
  always_comb begin
    enc = '1;
    sel = '0;
    if (!d_q) begin
      for (int k = WID - 1; k >= 0; k--) begin
        if (v_q[k]) begin
          enc    = k[OW-1:0];
          sel    = '0;
          sel[k] = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < WID; k++) begin
        if (v_q[k]) begin
          enc    = k[OW-1:0];
          sel    = '0;
          sel[k] = 1'b1;
        end
      end
    end
  end

  // At most one bit left means this beat is the final one (covers v==0 too).
  assign le_one = ((v_q & (v_q - 1'b1)) == '0);

  assign o_valid = (state_q == SCAN);
  assign busy    = o_valid;
  assign o       = o_valid ? enc : '1;
  assign last    = o_valid & le_one;
  assign empty   = o_valid & empty_q;
  assign acc     = o_valid & o_ready;

  // Next-state: a load always wins (abort/reload, or back-to-back after the
  // final beat); otherwise an accepted beat clears its bit and the final
  // accepted beat returns to IDLE.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    d_d     = d_q;
    empty_d = empty_q;
    if (ld) begin
      state_d = SCAN;
      v_d     = i;
      d_d     = dir;
      empty_d = (i == '0);
    end else if (acc) begin
      v_d = v_q & ~sel;
      if (le_one) state_d = IDLE;
    end
  end

  // State and scan registers; rst overrides everything including ld.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_q     <= '0;
      d_q     <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      d_q     <= d_d;
      empty_q <= empty_d;
    end
  end

`ifdef FLO_SCAN_POPCNT_EN
  logic [OW-1:0] cnt_q, cnt_d;

  // Population count of the incoming vector, latched only on load.
  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = '0;
      for (int k = 0; k < WID; k++) cnt_d = cnt_d + {{(OW-1){1'b0}}, i[k]};
    end
  end

  // Count register: holds through the scan, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
`else
  assign cnt = '0;
`endif

endmodule

// File: tb/tb_flo_scan.sv
// Directed, table-driven bench for flo_scan (WID=64, OW=7).
module tb_flo_scan;

  localparam int WID = 64;
  localparam int OW  = 7;
  localparam logic [OW-1:0] NONE = 7'h7F;
  localparam logic [WID-1:0] V1 = 64'h8000_0000_0001_0010;

  logic           clk = 1'b0;
  logic           rst, ld, dir, o_ready;
  logic [WID-1:0] i;
  logic           busy, o_valid, last, empty;
  logic [OW-1:0]  o, cnt;

  int checks = 0;
  int failures = 0;

  flo_scan #(.WID(WID)) dut (
    .clk(clk), .rst(rst), .ld(ld), .i(i), .dir(dir),
    .busy(busy), .o_valid(o_valid), .o_ready(o_ready),
    .o(o), .last(last), .empty(empty), .cnt(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           ld;
    logic [WID-1:0] iv;
    logic           dir;
    logic           rdy;
    logic           e_vld;
    logic [OW-1:0]  e_o;
    logic           e_last;
    logic           e_empty;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic l, input logic [WID-1:0] iv, input logic dr,
                     input logic rd, input logic ev, input logic [OW-1:0] eo,
                     input logic el, input logic ee);
    vec_t r;
    r.ld = l; r.iv = iv; r.dir = dr; r.rdy = rd;
    r.e_vld = ev; r.e_o = eo; r.e_last = el; r.e_empty = ee;
    tbl.push_back(r);
  endtask

  // Compare {busy, o_valid, o, last, empty} against expectation.
  task automatic chk(input string nm, input logic ev, input logic [OW-1:0] eo,
                     input logic el, input logic ee);
    checks++;
    if (busy !== ev || o_valid !== ev || o !== eo || last !== el || empty !== ee) begin
      failures++;
      $display("FAIL %s: got busy=%b vld=%b o=%0d last=%b empty=%b, want busy=%b vld=%b o=%0d last=%b empty=%b",
               nm, busy, o_valid, o, last, empty, ev, ev, eo, el, ee);
    end
  endtask

  task automatic chk_cnt(input string nm, input logic [OW-1:0] ec);
    checks++;
    if (cnt !== ec) begin
      failures++;
      $display("FAIL %s: got cnt=%0d want cnt=%0d", nm, cnt, ec);
    end
  endtask

  localparam logic [OW-1:0] CNT_V1 =
`ifdef FLO_SCAN_POPCNT_EN
    7'd3;
`else
    7'd0;
`endif

  initial begin
    rst = 1'b1; ld = 1'b0; dir = 1'b0; o_ready = 1'b0; i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset", 1'b0, NONE, 1'b0, 1'b0);
    chk_cnt("reset_cnt", 7'd0);

    // ld  i        dir rdy | vld o    last empty
    add(1, V1,       0, 1,    0, NONE, 0, 0);
    add(0, '0,       0, 1,    1, 7'd4, 0, 0);
    add(0, '0,       0, 1,    1, 7'd16,0, 0);
    add(0, '0,       0, 1,    1, 7'd63,1, 0);
    add(0, '0,       0, 1,    0, NONE, 0, 0);
    add(1, V1,       1, 1,    0, NONE, 0, 0);
    add(0, '0,       0, 1,    1, 7'd63,0, 0);
    add(0, '0,       0, 1,    1, 7'd16,0, 0);
    add(0, '0,       0, 1,    1, 7'd4, 1, 0);
    add(0, '0,       0, 1,    0, NONE, 0, 0);
    add(1, '0,       0, 1,    0, NONE, 0, 0);
    add(0, '0,       0, 1,    1, NONE, 1, 1);
    add(0, '0,       0, 1,    0, NONE, 0, 0);
    add(1, 64'hA0,   0, 0,    0, NONE, 0, 0);
    add(0, '0,       0, 0,    1, 7'd5, 0, 0);
    add(0, '0,       0, 0,    1, 7'd5, 0, 0);
    add(0, '0,       0, 0,    1, 7'd5, 0, 0);
    add(0, '0,       0, 1,    1, 7'd5, 0, 0);
    add(0, '0,       0, 1,    1, 7'd7, 1, 0);
    add(0, '0,       0, 1,    0, NONE, 0, 0);
    add(1, V1,       0, 1,    0, NONE, 0, 0);
    add(0, '0,       0, 1,    1, 7'd4, 0, 0);
    add(1, 64'h1,    0, 1,    1, 7'd16,0, 0);
    add(0, '0,       0, 1,    1, 7'd0, 1, 0);
    add(0, '0,       0, 1,    0, NONE, 0, 0);
    add(1, 64'h2,    0, 1,    0, NONE, 0, 0);
    add(1, 64'h8,    0, 1,    1, 7'd1, 1, 0);
    add(0, '0,       0, 1,    1, 7'd3, 1, 0);
    add(0, '0,       0, 1,    0, NONE, 0, 0);

    foreach (tbl[k]) begin
      ld = tbl[k].ld; i = tbl[k].iv; dir = tbl[k].dir; o_ready = tbl[k].rdy;
      #1;
      chk($sformatf("vec%0d", k), tbl[k].e_vld, tbl[k].e_o, tbl[k].e_last, tbl[k].e_empty);
      @(negedge clk);
    end

    // Popcount of the test-1 vector, visible from the first valid cycle.
    ld = 1'b1; i = V1; dir = 1'b0; o_ready = 1'b0;
    @(negedge clk);
    ld = 1'b0; i = '0;
    chk("pc_first", 1'b1, 7'd4, 1'b0, 1'b0);
    chk_cnt("pc_cnt", CNT_V1);
    o_ready = 1'b1;
    @(negedge clk);
    chk("pc_second", 1'b1, 7'd16, 1'b0, 1'b0);
    chk_cnt("pc_cnt_hold", CNT_V1);

    // Reset mid-scan, with a simultaneous load that must lose.
    rst = 1'b1; ld = 1'b1; i = 64'hF;
    @(negedge clk);
    rst = 1'b0; ld = 1'b0; i = '0;
    chk("rst_mid", 1'b0, NONE, 1'b0, 1'b0);
    chk_cnt("rst_mid_cnt", 7'd0);
    @(negedge clk);
    chk("rst_after", 1'b0, NONE, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
